sram_like_req_arbiter: RTL and testbench

//  Arbitrates N_CH SRAM-like masters (IF inst port, EXE/MEM data port, later more) onto one SRAM-like slave port.

---
 rtl/sram_like_req_arbiter_if.sv | 54 +++++
 rtl/sram_like_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_like_req_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sram_like_req_arbiter_if.sv
// SRAM-like arbiter bundle: N_CH master-side request/response channels,
// one slave-side request/response port, and the arbiter status outputs.
// The arbiter uses the slave modport; the environment driving the masters
// and modelling the memory uses the master modport.
interface sram_like_req_arbiter_if #(
    parameter int N_CH  = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // master channels (flattened, channel i occupies slice i)
    logic [N_CH-1:0]        m_req;
    logic [N_CH-1:0]        m_wr;
    logic [2*N_CH-1:0]      m_size;
    logic [DW/8*N_CH-1:0]   m_wstrb;
    logic [AW*N_CH-1:0]     m_addr;
    logic [DW*N_CH-1:0]     m_wdata;
    logic [N_CH-1:0]        m_addr_ok;
    logic [N_CH-1:0]        m_data_ok;
    logic [DW-1:0]          m_rdata;

    // slave port
    logic                   s_req;
    logic                   s_wr;
    logic [1:0]             s_size;
    logic [DW/8-1:0]        s_wstrb;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wdata;
    logic                   s_addr_ok;
    logic                   s_data_ok;
    logic [DW-1:0]          s_rdata;

    // status
    logic [CW-1:0]          outstanding;
    logic                   resp_err;

    modport slave (
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  s_addr_ok, s_data_ok, s_rdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        output outstanding, resp_err
    );

    modport master (
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output s_addr_ok, s_data_ok, s_rdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        input  outstanding, resp_err
    );
endinterface

// File: rtl/sram_like_req_arbiter.sv
// N_CH-to-1 SRAM-like request arbiter with an in-order ID FIFO that routes
// each slave response back to the channel that issued the request.
// Handshakes pass straight through combinationally (zero added latency).
// A request that is presented but not yet accepted locks the grant so the
// slave-side fields stay stable until addr_ok.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> rotating priority starting at rr_ptr
//   undefined -> fixed priority, highest channel index wins
module sram_like_req_arbiter #(
    parameter int N_CH  = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_like_req_arbiter_if.slave bus
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DW / 8;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t   state_r;
    lock_state_t   state_nxt_s;
    logic [IW-1:0] lock_id_r;
    logic [IW-1:0] winner_s;
    logic [IW-1:0] grant_s;
    logic [IW-1:0] fifo_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          resp_err_r;
    logic          not_full_s;
    logic          s_req_s;
    logic          stall_s;
    logic          accept_s;
    logic          pop_s;
    logic          orphan_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_r;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Rotating-priority winner: first requester at or after rr_ptr
    always_comb begin
        winner_s = {IW{1'b0}};
        found_s  = 1'b0;
        cand_s   = {IW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            cand_s   = IW'((int'(rr_ptr_r) + i) % N_CH);
            winner_s = (!found_s && bus.m_req[cand_s]) ? cand_s : winner_s;
            found_s  = found_s | bus.m_req[cand_s];
        end
    end

    // Rotate priority to just past the channel that was accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= {IW{1'b0}};
        end else if (accept_s) begin
            rr_ptr_r <= (grant_s == IW'(N_CH - 1)) ? {IW{1'b0}} : grant_s + IW'(1);
        end
    end
`else
    // Fixed-priority winner: highest requesting index (data over inst)
    always_comb begin
        winner_s = {IW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            winner_s = bus.m_req[i] ? IW'(i) : winner_s;
        end
    end
`endif

    // Grant selection and handshake qualifiers; a locked grant holds its owner
    always_comb begin
        if (state_r == ST_LOCKED) begin
            grant_s = lock_id_r;
        end else begin
            grant_s = winner_s;
        end
        not_full_s = (count_r < DEPTH_C);
        s_req_s    = ~reset & bus.m_req[grant_s] & not_full_s;
        stall_s    = s_req_s & ~bus.s_addr_ok;
        accept_s   = s_req_s & bus.s_addr_ok;
        pop_s      = ~reset & bus.s_data_ok & (count_r != {CW{1'b0}});
        orphan_s   = ~reset & bus.s_data_ok & (count_r == {CW{1'b0}});
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_OPEN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lock next state: stay locked only while the request is stalled
    always_comb begin
        state_nxt_s = ST_OPEN;
        case (state_r)
            ST_OPEN:   state_nxt_s = stall_s ? ST_LOCKED : ST_OPEN;
            ST_LOCKED: state_nxt_s = stall_s ? ST_LOCKED : ST_OPEN;
            default:   state_nxt_s = ST_OPEN;
        endcase
    end

    // Outputs: slave-side mux from grant, one-hot addr_ok / data_ok, status
    always_comb begin
        bus.s_req       = s_req_s;
        bus.s_wr        = bus.m_wr[grant_s];
        bus.s_size      = bus.m_size[int'(grant_s)*2 +: 2];
        bus.s_wstrb     = bus.m_wstrb[int'(grant_s)*BW +: BW];
        bus.s_addr      = bus.m_addr[int'(grant_s)*AW +: AW];
        bus.s_wdata     = bus.m_wdata[int'(grant_s)*DW +: DW];
        bus.m_rdata     = bus.s_rdata;
        bus.m_addr_ok   = {N_CH{1'b0}};
        bus.m_data_ok   = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            bus.m_addr_ok[i] = accept_s && (grant_s == IW'(i));
            bus.m_data_ok[i] = pop_s && (fifo_r[rd_ptr_r] == IW'(i));
        end
        bus.outstanding = count_r;
        bus.resp_err    = resp_err_r & ~reset;
    end

    // ID FIFO, occupancy count, lock owner and sticky orphan-response flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            lock_id_r  <= {IW{1'b0}};
            resp_err_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {IW{1'b0}};
            end
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= grant_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (stall_s) begin
                lock_id_r <= grant_s;
            end
            if (orphan_s) begin
                resp_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_like_req_arbiter.sv
// Directed table-driven bench for sram_like_req_arbiter (N_CH=2, DEPTH=4).
module tb_sram_like_req_arbiter;
    localparam int N_CH  = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    localparam logic [31:0] ADDR0  = 32'h0000_1000;
    localparam logic [31:0] ADDR1  = 32'h0000_2004;
    localparam logic [31:0] WDATA0 = 32'hAAAA_0000;
    localparam logic [31:0] WDATA1 = 32'h5555_1111;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    sram_like_req_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    sram_like_req_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_sreq;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic [2:0]  exp_out;
        logic        exp_err;
        logic        chk_addr;
        logic        gnt;
    } vec_t;

    vec_t vecs [35];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rdata);
        bus.m_req     = req;
        bus.s_addr_ok = aok;
        bus.s_data_ok = dok;
        bus.s_rdata   = rdata;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        drive(t.req, t.aok, t.dok, t.rdata);
        #1;
        check("s_req", idx, 32'(bus.s_req), 32'(t.exp_sreq));
        check("m_addr_ok", idx, 32'(bus.m_addr_ok), 32'(t.exp_aok));
        check("m_data_ok", idx, 32'(bus.m_data_ok), 32'(t.exp_dok));
        check("outstanding", idx, 32'(bus.outstanding), 32'(t.exp_out));
        check("resp_err", idx, 32'(bus.resp_err), 32'(t.exp_err));
        if (t.dok) begin
            check("m_rdata", idx, bus.m_rdata, t.rdata);
        end
        if (t.chk_addr) begin
            check("s_addr", idx, bus.s_addr, t.gnt ? ADDR1 : ADDR0);
            check("s_wr", idx, 32'(bus.s_wr), 32'(t.gnt));
            check("s_wdata", idx, bus.s_wdata, t.gnt ? WDATA1 : WDATA0);
        end
    endtask

    initial begin
        logic [1:0] arb_exp [4];
        n_vec = 0;
        n_err = 0;

        // req, aok, dok, rdata, sreq, aok_m, dok_m, out, err, chk, gnt
        // both request, ch1 wins; response routed to ch1
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{2'b00, 1'b0, 1'b1, 32'h1234, 1'b0, 2'b00, 2'b10, 3'd1, 1'b0, 1'b0, 1'b0};
        // fill to DEPTH, full blocks, no bypass on pop, reopen, drain
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b01, 1'b1, 1'b1, 32'hA5,   1'b0, 2'b00, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 1'b1, 32'h11,   1'b0, 2'b00, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 1'b0, 1'b1, 32'h22,   1'b0, 2'b00, 2'b01, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b00, 1'b0, 1'b1, 32'h33,   1'b0, 2'b00, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{2'b00, 1'b0, 1'b1, 32'h44,   1'b0, 2'b00, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0};
        // orphan response sets sticky resp_err
        vecs[14] = '{2'b00, 1'b0, 1'b1, 32'h55,   1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0};
        // issue ch1,ch0,ch1 across pointer wrap, responses in order
        vecs[15] = '{2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd2, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{2'b00, 1'b0, 1'b1, 32'h61,   1'b0, 2'b00, 2'b10, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{2'b00, 1'b0, 1'b1, 32'h62,   1'b0, 2'b00, 2'b01, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{2'b00, 1'b0, 1'b1, 32'h63,   1'b0, 2'b00, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0};
        // lock on ch0 while stalled, ch1 arrives but must wait
        vecs[21] = '{2'b01, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{2'b01, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[23] = '{2'b11, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[24] = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[25] = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd1, 1'b1, 1'b1, 1'b1};
        // locked master withdraws: s_req drops, lock clears
        vecs[26] = '{2'b01, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00, 2'b00, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[27] = '{2'b10, 1'b0, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[28] = '{2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd2, 1'b1, 1'b1, 1'b1};
        vecs[29] = '{2'b00, 1'b0, 1'b1, 32'h71,   1'b0, 2'b00, 2'b01, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[30] = '{2'b00, 1'b0, 1'b1, 32'h72,   1'b0, 2'b00, 2'b10, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[31] = '{2'b00, 1'b0, 1'b1, 32'h73,   1'b0, 2'b00, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0};
        // simultaneous push and pop keeps count
        vecs[32] = '{2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[33] = '{2'b01, 1'b1, 1'b1, 32'h81,   1'b1, 2'b01, 2'b10, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[34] = '{2'b00, 1'b0, 1'b1, 32'h82,   1'b0, 2'b00, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0};

        bus.m_wr    = 2'b10;
        bus.m_size  = {2'd1, 2'd2};
        bus.m_wstrb = {4'h3, 4'hF};
        bus.m_addr  = {ADDR1, ADDR0};
        bus.m_wdata = {WDATA1, WDATA0};
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 35; i++) begin
            run_vec(vecs[i], i);
        end

        // reset clears count and sticky error; outputs quiet while in reset
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 32'h99);
        #1;
        check("rst_s_req", 100, 32'(bus.s_req), 32'd0);
        check("rst_m_addr_ok", 100, 32'(bus.m_addr_ok), 32'd0);
        check("rst_m_data_ok", 100, 32'(bus.m_data_ok), 32'd0);
        check("rst_resp_err", 100, 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check("post_rst_outstanding", 101, 32'(bus.outstanding), 32'd0);
        check("post_rst_resp_err", 101, 32'(bus.resp_err), 32'd0);

        // both channels held with addr_ok every cycle
`ifdef ARB_ROUND_ROBIN_EN
        arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01; arb_exp[3] = 2'b10;
`else
        arb_exp[0] = 2'b10; arb_exp[1] = 2'b10; arb_exp[2] = 2'b10; arb_exp[3] = 2'b10;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(2'b11, 1'b1, 1'b0, 32'h0);
            #1;
            check("arb_addr_ok", 200 + i, 32'(bus.m_addr_ok), 32'(arb_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(2'b00, 1'b0, 1'b1, 32'(i));
            #1;
            check("arb_data_ok", 210 + i, 32'(bus.m_data_ok), 32'(arb_exp[i]));
            check("arb_outstanding", 210 + i, 32'(bus.outstanding), 32'(4 - i));
        end
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        check("final_outstanding", 220, 32'(bus.outstanding), 32'd0);
        check("final_resp_err", 220, 32'(bus.resp_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
